// File: rtl/vec_dispatch_pkg.sv
// vec_dispatch_pkg: shared types and pointer helper for the vector dispatch queue.
package vec_dispatch_pkg;
    localparam int VD_XLEN = 64;
    localparam int VD_TRANS_ID_W = 3;

    typedef struct packed {
        logic [31:0]              instr;
        logic [VD_XLEN-1:0]       rs1;
        logic [VD_XLEN-1:0]       rs2;
        logic [VD_TRANS_ID_W-1:0] trans_id;
    } vec_dispatch_entry_t;

    typedef vec_dispatch_entry_t vec_acc_req_t;

    typedef struct packed {
        logic [VD_TRANS_ID_W-1:0] trans_id;
        logic [VD_XLEN-1:0]       result;
        logic                     exception;
    } vec_acc_resp_t;

    // Raw difference; callers truncate to pointer width so the wrap bit resolves.
    function automatic int unsigned ptr_count(input int unsigned wr, input int unsigned rd);
        return wr - rd;
    endfunction
endpackage

// File: rtl/vec_dispatch_queue.sv
// vec_dispatch_queue: buffers speculative vector instructions, releases committed ones
// to the accelerator, and registers accelerator results back to the scoreboard.
module vec_dispatch_queue
    import vec_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN = VD_XLEN,
    parameter int TRANS_ID_W = VD_TRANS_ID_W,
    parameter int MAX_OUTSTANDING = 4,
    localparam int PW = $clog2(DEPTH) + 1,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_instr_i,
    input  logic [XLEN-1:0]       issue_rs1_i,
    input  logic [XLEN-1:0]       issue_rs2_i,
    input  logic [TRANS_ID_W-1:0] issue_trans_id_i,
    input  logic                  commit_i,
    output logic                  acc_req_valid_o,
    input  logic                  acc_req_ready_i,
    output logic [31:0]           acc_req_instr_o,
    output logic [XLEN-1:0]       acc_req_rs1_o,
    output logic [XLEN-1:0]       acc_req_rs2_o,
    output logic [TRANS_ID_W-1:0] acc_req_trans_id_o,
    input  logic                  acc_resp_valid_i,
    input  logic [TRANS_ID_W-1:0] acc_resp_trans_id_i,
    input  logic [XLEN-1:0]       acc_resp_result_i,
    input  logic                  acc_resp_exception_i,
    output logic                  wb_valid_o,
    output logic [TRANS_ID_W-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]       wb_result_o,
    output logic                  wb_exception_o,
    output logic [OW-1:0]         outstanding_o,
    output logic                  idle_o
);
    logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr, cm_next;
    logic [OW-1:0] outstanding;
    logic full, issue_fire, commit_fire, req_fire, resp_fire;
    vec_dispatch_entry_t entries [DEPTH];
    vec_acc_req_t head;
    vec_acc_resp_t wb_q;
    logic wb_valid_q;

    assign full = PW'(ptr_count(32'(wr_ptr), 32'(rd_ptr))) == PW'(DEPTH);
    assign issue_ready_o = !full && !flush_i;
    assign issue_fire = issue_valid_i && issue_ready_o;
    assign commit_fire = commit_i && (cm_ptr != wr_ptr);
    assign cm_next = cm_ptr + PW'(commit_fire);
    assign head = entries[rd_ptr[PW-2:0]];
    assign acc_req_valid_o = (rd_ptr != cm_ptr) && (outstanding < OW'(MAX_OUTSTANDING));
    assign req_fire = acc_req_valid_o && acc_req_ready_i;
    assign resp_fire = acc_resp_valid_i && (outstanding != '0);

    assign acc_req_instr_o = head.instr;
    assign acc_req_rs1_o = head.rs1;
    assign acc_req_rs2_o = head.rs2;
    assign acc_req_trans_id_o = head.trans_id;
    assign wb_valid_o = wb_valid_q;
    assign wb_trans_id_o = wb_q.trans_id;
    assign wb_result_o = wb_q.result;
    assign wb_exception_o = wb_q.exception;
    assign outstanding_o = outstanding;
    assign idle_o = (wr_ptr == rd_ptr) && (outstanding == '0);

    // Flush rewinds the write pointer to the commit point, after this cycle's commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            rd_ptr <= '0;
            outstanding <= '0;
            wb_valid_q <= 1'b0;
            wb_q <= '0;
        end else begin
            wr_ptr <= flush_i ? cm_next : wr_ptr + PW'(issue_fire);
            cm_ptr <= cm_next;
            rd_ptr <= rd_ptr + PW'(req_fire);
            outstanding <= outstanding + OW'(req_fire) - OW'(resp_fire);
            wb_valid_q <= acc_resp_valid_i;
            wb_q <= '{trans_id: acc_resp_trans_id_i, result: acc_resp_result_i,
                      exception: acc_resp_exception_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue_fire)
            entries[wr_ptr[PW-2:0]] <= '{instr: issue_instr_i, rs1: issue_rs1_i,
                                         rs2: issue_rs2_i, trans_id: issue_trans_id_i};
    end

    a_commit_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        commit_i |-> cm_ptr != wr_ptr);
    a_resp_zero: assert property (@(posedge clk_i) disable iff (rst_i)
        acc_resp_valid_i |-> outstanding != '0);
    a_max_out: assert property (@(posedge clk_i) disable iff (rst_i)
        outstanding <= OW'(MAX_OUTSTANDING));
endmodule

// File: tb/tb_vec_dispatch_queue.sv
// tb_vec_dispatch_queue: directed and random stimulus against a queue-based reference
// model, with a separate monitor scoreboarding accelerator requests and writebacks.
module tb_vec_dispatch_queue;
    import vec_dispatch_pkg::*;

    logic clk_i = 0, rst_i = 1, flush_i = 0, issue_valid_i = 0, commit_i = 0;
    logic acc_req_ready_i = 0, acc_resp_valid_i = 0, acc_resp_exception_i = 0;
    logic [31:0] issue_instr_i = '0;
    logic [63:0] issue_rs1_i = '0, issue_rs2_i = '0, acc_resp_result_i = '0;
    logic [2:0] issue_trans_id_i = '0, acc_resp_trans_id_i = '0;
    logic issue_ready_o, acc_req_valid_o, wb_valid_o, wb_exception_o, idle_o;
    logic [31:0] acc_req_instr_o;
    logic [63:0] acc_req_rs1_o, acc_req_rs2_o, wb_result_o;
    logic [2:0] acc_req_trans_id_o, wb_trans_id_o, outstanding_o;

    vec_dispatch_queue dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_trans_id_i(issue_trans_id_i), .commit_i(commit_i),
        .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
        .acc_req_instr_o(acc_req_instr_o), .acc_req_rs1_o(acc_req_rs1_o),
        .acc_req_rs2_o(acc_req_rs2_o), .acc_req_trans_id_o(acc_req_trans_id_o),
        .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_trans_id_i(acc_resp_trans_id_i),
        .acc_resp_result_i(acc_resp_result_i), .acc_resp_exception_i(acc_resp_exception_i),
        .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
        .wb_exception_o(wb_exception_o), .outstanding_o(outstanding_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0, fails = 0, outst = 0;
    vec_dispatch_entry_t spec_q[$], com_q[$], exp_req[$];
    vec_acc_resp_t exp_wb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, check against model, advance the model at posedge.
    task automatic cyc(input bit iv, input logic [2:0] id, input bit c, input bit fl,
                       input bit rdy, input bit rv, input logic [2:0] rid,
                       input logic [63:0] rres, input bit rexc);
        vec_dispatch_entry_t e, h;
        bit full, rq, acc, rp;
        e = '{instr: $urandom, rs1: {$urandom, $urandom}, rs2: {$urandom, $urandom}, trans_id: id};
        issue_valid_i = iv;
        issue_instr_i = e.instr;
        issue_rs1_i = e.rs1;
        issue_rs2_i = e.rs2;
        issue_trans_id_i = id;
        commit_i = c;
        flush_i = fl;
        acc_req_ready_i = rdy;
        acc_resp_valid_i = rv;
        acc_resp_trans_id_i = rid;
        acc_resp_result_i = rres;
        acc_resp_exception_i = rexc;
        full = (spec_q.size() + com_q.size()) == 4;
        rq = com_q.size() > 0 && outst < 4;
        acc = iv && !full && !fl;
        rp = rv && outst > 0;
        #1;
        chk("issue_ready", 64'(issue_ready_o), 64'(!full && !fl));
        chk("acc_req_valid", 64'(acc_req_valid_o), 64'(rq));
        chk("outstanding", 64'(outstanding_o), 64'(outst));
        chk("idle", 64'(idle_o), 64'(spec_q.size() + com_q.size() == 0 && outst == 0));
        if (rq) begin
            chk("req_instr", 64'(acc_req_instr_o), 64'(com_q[0].instr));
            chk("req_rs1", acc_req_rs1_o, com_q[0].rs1);
            chk("req_id", 64'(acc_req_trans_id_o), 64'(com_q[0].trans_id));
        end
        @(posedge clk_i);
        if (rq && rdy) com_q.delete(0);
        if (c && spec_q.size() > 0) begin
            h = spec_q.pop_front();
            com_q.push_back(h);
            exp_req.push_back(h);
        end
        if (fl) spec_q.delete();
        if (acc) spec_q.push_back(e);
        outst = outst + int'(rq && rdy) - int'(rp);
        if (rv) exp_wb.push_back('{trans_id: rid, result: rres, exception: rexc});
        @(negedge clk_i);
    endtask

    task automatic idle_cyc(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, rdy, 0, 0, 0, 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, spec_q.size() > 0, 0, 1, outst > 0, 3'($urandom),
                {$urandom, $urandom}, 1'($urandom));
    endtask

    task automatic do_reset();
        rst_i = 1;
        issue_valid_i = 0; commit_i = 0; flush_i = 0;
        acc_req_ready_i = 0; acc_resp_valid_i = 0;
        #1;
        chk("rst_acc_req_valid", 64'(acc_req_valid_o), 0);
        chk("rst_outstanding", 64'(outstanding_o), 0);
        chk("rst_idle", 64'(idle_o), 1);
        chk("rst_issue_ready", 64'(issue_ready_o), 1);
        chk("rst_wb_valid", 64'(wb_valid_o), 0);
        chk("rst_wb_result", wb_result_o, 0);
        spec_q.delete(); com_q.delete(); exp_req.delete(); exp_wb.delete();
        outst = 0;
        @(negedge clk_i);
        rst_i = 0;
    endtask

    initial begin
        vec_dispatch_entry_t e;
        vec_acc_resp_t r;
        forever begin
            @(negedge clk_i);
            #2;
            if (!rst_i && acc_req_valid_o && acc_req_ready_i) begin
                tests++;
                if (exp_req.size() == 0) begin
                    fails++;
                    $display("FAIL req_unexpected: got id %0d expected no request", acc_req_trans_id_o);
                end else begin
                    e = exp_req.pop_front();
                    if (acc_req_instr_o !== e.instr || acc_req_rs1_o !== e.rs1 ||
                        acc_req_rs2_o !== e.rs2 || acc_req_trans_id_o !== e.trans_id) begin
                        fails++;
                        $display("FAIL req_order: got id %0d instr %0h expected id %0d instr %0h",
                                 acc_req_trans_id_o, acc_req_instr_o, e.trans_id, e.instr);
                    end
                end
            end
            if (wb_valid_o) begin
                tests++;
                if (exp_wb.size() == 0) begin
                    fails++;
                    $display("FAIL wb_unexpected: got id %0d expected no writeback", wb_trans_id_o);
                end else begin
                    r = exp_wb.pop_front();
                    if (wb_trans_id_o !== r.trans_id || wb_result_o !== r.result ||
                        wb_exception_o !== r.exception) begin
                        fails++;
                        $display("FAIL wb_data: got id %0d res %0h exc %0b expected id %0d res %0h exc %0b",
                                 wb_trans_id_o, wb_result_o, wb_exception_o,
                                 r.trans_id, r.result, r.exception);
                    end
                end
            end
        end
    end

    initial begin
        @(negedge clk_i);
        do_reset();
        // in-order dispatch two cycles after issue
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 2, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0, 0, 0, 0);
        idle_cyc(2, 1);
        cyc(0, 0, 0, 0, 1, 1, 1, 64'h11, 0);
        cyc(0, 0, 0, 0, 1, 1, 2, 64'h22, 1);
        idle_cyc(2, 1);
        // fill then flush
        for (int i = 0; i < 5; i++) cyc(1, 3'(i), 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle_cyc(2, 1);
        // flush and commit in the same cycle
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 4, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 6, 0, 0, 1, 0, 0, 0, 0);
        drain(12);
        // outstanding limit
        for (int i = 0; i < 8; i++) cyc(i < 5, 3'(i), spec_q.size() > 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 2, 64'hDEAD, 0);
        idle_cyc(2, 1);
        drain(10);
        // stalled request with flush pulsed
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 2, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain(10);
        // reset mid-stream
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 2, 1, 0, 1, 0, 0, 0, 0);
        cyc(1, 3, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        do_reset();
        idle_cyc(2, 1);
        // random traffic
        for (int i = 0; i < 1500; i++)
            cyc(1'($urandom), 3'($urandom), spec_q.size() > 0 && ($urandom_range(2) == 0),
                $urandom_range(19) == 0, $urandom_range(3) != 0,
                outst > 0 && ($urandom_range(2) == 0), 3'($urandom),
                {$urandom, $urandom}, 1'($urandom));
        drain(30);
        idle_cyc(2, 0);
        chk("req_drained", 64'(exp_req.size()), 0);
        chk("wb_drained", 64'(exp_wb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
